// File: rtl/steel_dmem_pkg.sv
// Shared types and helpers for the Steel data memory controller.
package steel_dmem_pkg;

    typedef enum logic [0:0] {
        DM_CLEAR = 1'b0,
        DM_RUN   = 1'b1
    } dm_state_e;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;

    // Unsigned window check; span is 33 bits so a window ending at 2^32 does not wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ({1'b0, off} < span);
    endfunction

    // Expand a byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_bits(input logic [NUM_LANES-1:0] mask);
        logic [31:0] bits;
        bits = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            bits[k*LANE_W +: LANE_W] = {LANE_W{mask[k]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/steel_dmem_ram.sv
// Word-addressed RAM with per-lane write enables and a registered read.
// Read returns the pre-write contents; the array itself is never reset.
module steel_dmem_ram
    import steel_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic [AW-1:0]        waddr,
    input  logic [31:0]          wdata,
    input  logic [NUM_LANES-1:0] wbe,
    input  logic [AW-1:0]        raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read mux ahead of the output register.
    always_comb begin
        rdata_d = mem[raddr];
    end

    // Lane-masked write and registered read.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (wbe[k]) begin
                mem[waddr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/steel_data_mem_ctrl.sv
// Data memory for the Steel core: clear sequencer, range check,
// write-first bypass and 1- or 2-cycle read pipe around steel_dmem_ram.
module steel_data_mem_ctrl
    import steel_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] DATA_OUT,
    input  logic        WR_REQ,
    input  logic [3:0]  WR_MASK,
    output logic [31:0] DATA_IN,
    output logic        ACCESS_FAULT,
    output logic        INIT_BUSY
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam dm_state_e   ST_RST = CLEAR_ON_RESET ? DM_CLEAR : DM_RUN;

    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of two >= 4");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (({1'b0, BASE_ADDR} % SPAN) != 33'd0) begin : g_bad_base
        $error("BASE_ADDR must be aligned to 4*DEPTH_WORDS");
    end

    dm_state_e      state_q, state_d;
    logic [AW-1:0]  clr_ptr_q, clr_ptr_d;
    logic           rd_ok_q, rd_ok_d;
    logic           fault_q, fault_d;
    logic [3:0]     byp_mask_q, byp_mask_d;
    logic [31:0]    byp_data_q, byp_data_d;

    logic           in_range;
    logic [AW-1:0]  core_idx;
    logic [3:0]     core_wbe;
    logic [AW-1:0]  ram_waddr;
    logic [31:0]    ram_wdata;
    logic [3:0]     ram_wbe;
    logic [31:0]    ram_rdata;
    logic [31:0]    s1_data;

    assign in_range = addr_in_range(D_ADDR, BASE_ADDR, SPAN);
    assign core_idx = AW'((D_ADDR - BASE_ADDR) >> 2);
    assign core_wbe = (WR_REQ && in_range) ? WR_MASK : 4'b0000;

    // State and clear-pointer register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_RST;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: walk the clear pointer once over the array, then stay in RUN.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            DM_CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d   = DM_RUN;
                    clr_ptr_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs of the FSM: busy flag and RAM write-port mux (clear vs. core).
    always_comb begin
        INIT_BUSY = (state_q == DM_CLEAR);
        if (state_q == DM_CLEAR) begin
            ram_waddr = clr_ptr_q;
            ram_wdata = '0;
            ram_wbe   = '1;
        end else begin
            ram_waddr = core_idx;
            ram_wdata = DATA_OUT;
            ram_wbe   = core_wbe;
        end
    end

    steel_dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (CLK),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wbe   (ram_wbe),
        .raddr (core_idx),
        .rdata (ram_rdata)
    );

    // Read-side sideband for the sample: valid/fault flags and the lanes written
    // this cycle, which are merged over the RAM's pre-write read data.
    always_comb begin
        rd_ok_d    = (state_q == DM_RUN) && in_range;
        fault_d    = (state_q == DM_RUN) && !in_range;
        byp_mask_d = (state_q == DM_RUN) ? core_wbe : 4'b0000;
        byp_data_d = DATA_OUT;
        s1_data    = rd_ok_q ? ((ram_rdata & ~lane_bits(byp_mask_q)) |
                                (byp_data_q & lane_bits(byp_mask_q)))
                             : '0;
    end

    // First read stage flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ok_q    <= 1'b0;
            fault_q    <= 1'b0;
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else begin
            rd_ok_q    <= rd_ok_d;
            fault_q    <= fault_d;
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [31:0] pipe_data_q, pipe_data_d;
        logic        pipe_fault_q, pipe_fault_d;

        assign pipe_data_d  = s1_data;
        assign pipe_fault_d = fault_q;

        // Extra output register for two-cycle latency.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                pipe_data_q  <= '0;
                pipe_fault_q <= 1'b0;
            end else begin
                pipe_data_q  <= pipe_data_d;
                pipe_fault_q <= pipe_fault_d;
            end
        end

        assign DATA_IN      = pipe_data_q;
        assign ACCESS_FAULT = pipe_fault_q;
    end else begin : g_lat1
        assign DATA_IN      = s1_data;
        assign ACCESS_FAULT = fault_q;
    end

endmodule

// File: tb/tb_steel_data_mem_ctrl.sv
// Scoreboard bench for steel_data_mem_ctrl (DEPTH=16, BASE=0x1000, latency 2).
module tb_steel_data_mem_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LAT   = 2;

    logic        clk;
    logic        RESET;
    logic [31:0] D_ADDR;
    logic [31:0] DATA_OUT;
    logic        WR_REQ;
    logic [3:0]  WR_MASK;
    logic [31:0] DATA_IN;
    logic        ACCESS_FAULT;
    logic        INIT_BUSY;

    steel_data_mem_ctrl #(
        .DEPTH_WORDS    (DEPTH),
        .BASE_ADDR      (BASE),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .CLK          (clk),
        .RESET        (RESET),
        .D_ADDR       (D_ADDR),
        .DATA_OUT     (DATA_OUT),
        .WR_REQ       (WR_REQ),
        .WR_MASK      (WR_MASK),
        .DATA_IN      (DATA_IN),
        .ACCESS_FAULT (ACCESS_FAULT),
        .INIT_BUSY    (INIT_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          step_id;
        bit          is_busy;
        logic [31:0] data;
        logic        fault;
        logic        busy;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          step_no = 0;

    // Reference model: plain word array, clear countdown.
    logic [31:0] mmem [DEPTH];
    int          clear_left = 0;

    function automatic bit model_in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                if (sb[i].is_busy) begin
                    checks++;
                    if (INIT_BUSY !== sb[i].busy) begin
                        errors++;
                        $display("FAIL init_busy step=%0d got=%b exp=%b", sb[i].step_id, INIT_BUSY, sb[i].busy);
                    end
                end else begin
                    checks++;
                    if (DATA_IN !== sb[i].data) begin
                        errors++;
                        $display("FAIL data_in step=%0d got=%h exp=%h", sb[i].step_id, DATA_IN, sb[i].data);
                    end
                    checks++;
                    if (ACCESS_FAULT !== sb[i].fault) begin
                        errors++;
                        $display("FAIL access_fault step=%0d got=%b exp=%b", sb[i].step_id, ACCESS_FAULT, sb[i].fault);
                    end
                end
                sb.delete(i);
            end
        end
    end

    // One core cycle: drive inputs, predict, then advance to just after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [3:0] m);
        exp_t        e;
        int unsigned ix;
        bit          clr;
        D_ADDR   = a;
        DATA_OUT = d;
        WR_REQ   = we;
        WR_MASK  = m;
        step_no++;
        clr = (clear_left > 0);
        if (clr) clear_left--;
        e.due = cyc; e.step_id = step_no; e.is_busy = 1'b1;
        e.busy = clr; e.data = '0; e.fault = 1'b0;
        sb.push_back(e);
        e.is_busy = 1'b0;
        e.due     = cyc + LAT;
        if (clr) begin
            e.data = '0; e.fault = 1'b0;
        end else if (model_in_range(a)) begin
            ix = (a - BASE) / 4;
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (m[k]) mmem[ix][8*k +: 8] = d[8*k +: 8];
            end
            e.data = mmem[ix]; e.fault = 1'b0;
        end else begin
            e.data = '0; e.fault = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) step(a, 32'h0, 1'b0, 4'h0);
    endtask

    // Assert reset (asynchronously), check reset outputs, release after 3 edges.
    task automatic do_reset();
        RESET = 1'b1; WR_REQ = 1'b0; WR_MASK = '0; D_ADDR = BASE; DATA_OUT = '0;
        sb.delete();
        #1;
        checks++;
        if (DATA_IN !== 32'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=%h", DATA_IN, 32'h0);
        end
        checks++;
        if (ACCESS_FAULT !== 1'b0) begin
            errors++; $display("FAIL reset_fault got=%b exp=0", ACCESS_FAULT);
        end
        checks++;
        if (INIT_BUSY !== 1'b1) begin
            errors++; $display("FAIL reset_busy got=%b exp=1", INIT_BUSY);
        end
        repeat (3) @(posedge clk);
        #1;
        RESET = 1'b0;
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    endtask

    initial begin
        RESET = 1'b1; D_ADDR = BASE; DATA_OUT = '0; WR_REQ = 1'b0; WR_MASK = '0;
        @(posedge clk);
        #1;

        // Clear sequence length; store while busy is dropped.
        do_reset();
        step(BASE + 32'h0, 32'h5, 1'b1, 4'hF);
        idle(19, BASE + 32'h8);
        for (int i = 0; i < DEPTH; i++) step(BASE + 32'(4 * i), 32'h0, 1'b0, 4'h0);

        // Partial-lane store.
        step(BASE + 32'h8, 32'hDEAD_BEEF, 1'b1, 4'hF);
        step(BASE + 32'h8, 32'h0000_00AA, 1'b1, 4'b0001);
        step(BASE + 32'h8, 32'h0, 1'b0, 4'h0);

        // Same-cycle write and read: write-first.
        step(BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 4'hF);
        step(BASE + 32'h4, 32'h1234_0000, 1'b1, 4'b1100);
        step(BASE + 32'h4, 32'h0, 1'b0, 4'h0);

        // Range edges, back-to-back faults, dropped out-of-range store, zero mask.
        step(32'h0000_0FFC, 32'h0, 1'b0, 4'h0);
        step(32'h0000_1040, 32'h0, 1'b0, 4'h0);
        step(32'h0000_1040, 32'hCAFE_F00D, 1'b1, 4'hF);
        step(BASE + 32'h0, 32'h0, 1'b0, 4'h0);
        step(32'h0000_103C, 32'h0, 1'b0, 4'h0);
        step(BASE + 32'h8, 32'hFFFF_FFFF, 1'b1, 4'h0);
        step(BASE + 32'h8, 32'h0, 1'b0, 4'h0);
        step(32'hFFFF_FFFC, 32'h0, 1'b0, 4'h0);

        // Reset partway through the clear restarts the full sequence.
        do_reset();
        idle(7, BASE);
        do_reset();
        idle(20, BASE + 32'hC);

        // Randomised traffic around the window.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = 32'h0000_0FF0 + 32'($urandom_range(0, 'h68));
            step(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        // Reset from RUN re-zeroes the array.
        do_reset();
        idle(20, BASE);
        for (int i = 0; i < DEPTH; i++) step(BASE + 32'(4 * i), 32'h0, 1'b0, 4'h0);

        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
